// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the RV32I multi-cycle control path
// (opcodes, immediate-extender selects, PC-source selects, FSM states,
// instruction classes).
package rv_ctrl_pkg;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    // funct3 values that turn an OP-IMM into a shift-immediate
    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;

    // Immediate-extender select, must match the extender's case table
    localparam logic [2:0] IMM_LOAD   = 3'b000;
    localparam logic [2:0] IMM_ALUI   = 3'b001;
    localparam logic [2:0] IMM_SHIFT  = 3'b010;
    localparam logic [2:0] IMM_STORE  = 3'b011;
    localparam logic [2:0] IMM_UPPER  = 3'b100;
    localparam logic [2:0] IMM_BRANCH = 3'b101;
    localparam logic [2:0] IMM_JALR   = 3'b110;
    localparam logic [2:0] IMM_JAL    = 3'b111;
    localparam logic [2:0] IMM_RTYPE  = 3'b000;  // no immediate; value unused

    // Next-PC source select
    localparam logic [1:0] PCSEL_PC4    = 2'b00;
    localparam logic [1:0] PCSEL_PCIMM  = 2'b01;
    localparam logic [1:0] PCSEL_RS1IMM = 2'b10;

    // FSM states; encoding is visible on o_state for debug
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // Instruction classes as seen by the sequencer
    typedef enum logic [3:0] {
        CLS_LOAD, CLS_ALUI, CLS_SHIFTI, CLS_STORE, CLS_UPPER,
        CLS_BRANCH, CLS_JALR, CLS_JAL, CLS_RTYPE, CLS_ILLEGAL
    } inst_class_e;

endpackage

// File: rtl/inst_class_decode.sv
// inst_class_decode: purely combinational opcode/funct3 classifier that
// yields the instruction class and the immediate-extender select.
module inst_class_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output logic [3:0] o_class,
    output logic [2:0] o_immSrc
);

    inst_class_e w_cls;

    // Map the opcode (and funct3 for OP-IMM) to class and immediate format
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value held over, which would infer a latch.
        w_cls    = CLS_ILLEGAL;
        o_immSrc = IMM_LOAD;
        case (i_opcode)
            OP_LOAD:   begin w_cls = CLS_LOAD;   o_immSrc = IMM_LOAD;   end
            OP_ALUI: begin
                if (i_funct3 == F3_SLLI || i_funct3 == F3_SRXI) begin
                    w_cls    = CLS_SHIFTI;
                    o_immSrc = IMM_SHIFT;
                end else begin
                    w_cls    = CLS_ALUI;
                    o_immSrc = IMM_ALUI;
                end
            end
            OP_STORE:  begin w_cls = CLS_STORE;  o_immSrc = IMM_STORE;  end
            OP_LUI,
            OP_AUIPC:  begin w_cls = CLS_UPPER;  o_immSrc = IMM_UPPER;  end
            OP_BRANCH: begin w_cls = CLS_BRANCH; o_immSrc = IMM_BRANCH; end
            OP_JALR:   begin w_cls = CLS_JALR;   o_immSrc = IMM_JALR;   end
            OP_JAL:    begin w_cls = CLS_JAL;    o_immSrc = IMM_JAL;    end
            OP_RTYPE:  begin w_cls = CLS_RTYPE;  o_immSrc = IMM_RTYPE;  end
            default:   begin w_cls = CLS_ILLEGAL; o_immSrc = IMM_LOAD;  end
        endcase
    end

    assign o_class = w_cls;

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for the
// multi-cycle RV32I core, with sticky illegal-opcode trap and a
// retired-instruction counter.
module multicycle_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_fetchData,
    input  logic             i_fetchValid,
    input  logic             i_memReady,
    input  logic             i_branchTaken,
    output logic             o_fetchReq,
    output logic [31:0]      o_inst,
    output logic [2:0]       o_immSrc,
    output logic             o_memReq,
    output logic             o_memWe,
    output logic             o_regWrite,
    output logic             o_pcWrite,
    output logic [1:0]       o_pcSel,
    output logic [2:0]       o_state,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_instret
);

    state_e           r_state;
    logic [31:0]      r_inst;
    logic [2:0]       r_immSrc;
    inst_class_e      r_class;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;

    logic [3:0]       w_decClass;
    logic [2:0]       w_decImmSrc;
    logic             w_fetchReq;
    logic             w_memReq;
    logic             w_memWe;
    logic             w_regWrite;
    logic             w_pcWrite;
    logic [1:0]       w_pcSel;
    logic             w_isStore;

    inst_class_decode u_decode (
        .i_opcode (r_inst[6:0]),
        .i_funct3 (r_inst[14:12]),
        .o_class  (w_decClass),
        .o_immSrc (w_decImmSrc)
    );

    assign w_isStore = (r_class == CLS_STORE);

    // Strobes and requests: the retiring strobe must fire in the same cycle
    // as the branch result / memory-ready input, so they decode the current
    // state plus those inputs rather than being registered a cycle early.
    always_comb begin
        w_fetchReq = 1'b0;
        w_memReq   = 1'b0;
        w_memWe    = 1'b0;
        w_regWrite = 1'b0;
        w_pcWrite  = 1'b0;
        w_pcSel    = PCSEL_PC4;
        case (r_state)
            ST_FETCH: w_fetchReq = 1'b1;
            ST_EXEC: begin
                if (r_class == CLS_BRANCH) begin
                    w_pcWrite = 1'b1;
                    w_pcSel   = i_branchTaken ? PCSEL_PCIMM : PCSEL_PC4;
                end
            end
            ST_MEM: begin
                w_memReq  = 1'b1;
                w_memWe   = w_isStore;
                w_pcWrite = w_isStore && i_memReady;
            end
            ST_WB: begin
                w_regWrite = 1'b1;
                w_pcWrite  = 1'b1;
                if (r_class == CLS_JAL)       w_pcSel = PCSEL_PCIMM;
                else if (r_class == CLS_JALR) w_pcSel = PCSEL_RS1IMM;
                else                          w_pcSel = PCSEL_PC4;
            end
            default: ;
        endcase
    end

    // Sequencer state, IR, immediate select, trap flag and retire counter
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments throughout, so every register in
        // this block updates from pre-edge values regardless of order.
        if (i_rst) begin
            r_state   <= ST_FETCH;
            r_inst    <= '0;
            r_immSrc  <= IMM_LOAD;
            r_class   <= CLS_RTYPE;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_pcWrite) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            case (r_state)
                ST_FETCH: begin
                    if (i_fetchValid) begin
                        r_inst  <= i_fetchData;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Unsupported opcodes leave the previous immSrc in place
                    if (w_decClass == CLS_ILLEGAL) begin
                        r_illegal <= 1'b1;
                        r_state   <= ST_TRAP;
                    end else begin
                        r_class  <= inst_class_e'(w_decClass);
                        r_immSrc <= w_decImmSrc;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_class == CLS_BRANCH)
                        r_state <= ST_FETCH;
                    else if (r_class == CLS_LOAD || r_class == CLS_STORE)
                        r_state <= ST_MEM;
                    else
                        r_state <= ST_WB;
                end
                ST_MEM: begin
                    if (i_memReady) begin
                        r_state <= w_isStore ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Reset forces every output low in the reset cycle itself, so an
    // in-flight request or strobe is withdrawn immediately, not an edge later.
    assign o_fetchReq = w_fetchReq & ~i_rst;
    assign o_memReq   = w_memReq   & ~i_rst;
    assign o_memWe    = w_memWe    & ~i_rst;
    assign o_regWrite = w_regWrite & ~i_rst;
    assign o_pcWrite  = w_pcWrite  & ~i_rst;
    assign o_pcSel    = i_rst ? 2'b00 : w_pcSel;
    assign o_state    = i_rst ? 3'd0 : r_state;
    assign o_inst     = i_rst ? 32'd0 : r_inst;
    assign o_immSrc   = i_rst ? 3'd0 : r_immSrc;
    assign o_illegal  = r_illegal & ~i_rst;
    assign o_instret  = i_rst ? '0 : r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed + randomized stimulus against a
// per-instruction cycle-trace model built from the opcode classes and
// latency rules. A second instance with a 4-bit counter checks wrap-around.
module tb_multicycle_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_fetchData;
    logic        i_fetchValid;
    logic        i_memReady;
    logic        i_branchTaken;

    logic        fetch_req, mem_req, mem_we, reg_write, pc_write, illegal;
    logic [31:0] inst_q, instret;
    logic [2:0]  imm_src, state;
    logic [1:0]  pc_sel;

    logic        fetch_req4, mem_req4, mem_we4, reg_write4, pc_write4, illegal4;
    logic [31:0] inst_q4;
    logic [2:0]  imm_src4, state4;
    logic [1:0]  pc_sel4;
    logic [3:0]  instret4;

    always #5 i_clk = ~i_clk;

    multicycle_sequencer #(.CNT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_fetchData(i_fetchData),
        .i_fetchValid(i_fetchValid), .i_memReady(i_memReady),
        .i_branchTaken(i_branchTaken), .o_fetchReq(fetch_req), .o_inst(inst_q),
        .o_immSrc(imm_src), .o_memReq(mem_req), .o_memWe(mem_we),
        .o_regWrite(reg_write), .o_pcWrite(pc_write), .o_pcSel(pc_sel),
        .o_state(state), .o_illegal(illegal), .o_instret(instret)
    );

    multicycle_sequencer #(.CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_fetchData(i_fetchData),
        .i_fetchValid(i_fetchValid), .i_memReady(i_memReady),
        .i_branchTaken(i_branchTaken), .o_fetchReq(fetch_req4), .o_inst(inst_q4),
        .o_immSrc(imm_src4), .o_memReq(mem_req4), .o_memWe(mem_we4),
        .o_regWrite(reg_write4), .o_pcWrite(pc_write4), .o_pcSel(pc_sel4),
        .o_state(state4), .o_illegal(illegal4), .o_instret(instret4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model state
    logic [31:0] m_ir;
    logic [2:0]  m_imm;
    logic        m_ill;
    int unsigned m_cnt;

    localparam int K_LOAD = 0, K_ALUI = 1, K_SHIFT = 2, K_STORE = 3, K_UPPER = 4,
                   K_BRANCH = 5, K_JALR = 6, K_JAL = 7, K_RTYPE = 8, K_ILL = 9;

    // One expected cycle: inputs to drive and outputs to see
    typedef struct {
        logic        rst;
        logic        fv;
        logic [31:0] fd;
        logic        mr;
        logic        bt;
        logic [2:0]  st;
        logic        freq, mreq, mwe, rw, pw;
        logic [1:0]  ps;
    } cyc_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int kind_of(input logic [31:0] w);
        case (w[6:0])
            7'h03:        return K_LOAD;
            7'h13:        return (w[14:12] == 3'b001 || w[14:12] == 3'b101) ? K_SHIFT : K_ALUI;
            7'h23:        return K_STORE;
            7'h37, 7'h17: return K_UPPER;
            7'h63:        return K_BRANCH;
            7'h67:        return K_JALR;
            7'h6F:        return K_JAL;
            7'h33:        return K_RTYPE;
            default:      return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input int k);
        case (k)
            K_LOAD:   return 3'b000;
            K_ALUI:   return 3'b001;
            K_SHIFT:  return 3'b010;
            K_STORE:  return 3'b011;
            K_UPPER:  return 3'b100;
            K_BRANCH: return 3'b101;
            K_JALR:   return 3'b110;
            K_JAL:    return 3'b111;
            default:  return 3'b000;
        endcase
    endfunction

    // A cycle with no expected activity; inputs are random noise that the
    // DUT must ignore in this state.
    function automatic cyc_t idle(input logic [2:0] st);
        cyc_t c;
        c.rst = 1'b0; c.fv = 1'($urandom); c.fd = $urandom; c.mr = 1'($urandom);
        c.bt = 1'($urandom); c.st = st;
        c.freq = 0; c.mreq = 0; c.mwe = 0; c.rw = 0; c.pw = 0; c.ps = 2'b00;
        return c;
    endfunction

    task automatic run_cycle(input cyc_t c);
        int k;
        @(negedge i_clk);
        i_rst = c.rst; i_fetchValid = c.fv; i_fetchData = c.fd;
        i_memReady = c.mr; i_branchTaken = c.bt;
        if (c.rst) begin
            m_ir = '0; m_imm = '0; m_ill = 1'b0; m_cnt = 0;
        end
        #1;
        check("ctl", {22'd0, state, fetch_req, mem_req, mem_we, reg_write, pc_write, pc_sel},
                     {22'd0, c.st, c.freq, c.mreq, c.mwe, c.rw, c.pw, c.ps});
        check("imm", {29'd0, imm_src}, {29'd0, m_imm});
        check("ill", {31'd0, illegal}, {31'd0, m_ill});
        check("ir", inst_q, m_ir);
        check("instret", instret, m_cnt);
        check("instret4", {28'd0, instret4}, {28'd0, m_cnt[3:0]});
        if (!c.rst) begin
            if (c.st == 3'd0 && c.fv) m_ir = c.fd;
            if (c.st == 3'd1) begin
                k = kind_of(m_ir);
                if (k == K_ILL) m_ill = 1'b1;
                else            m_imm = imm_of(k);
            end
            if (c.pw) m_cnt++;
        end
    endtask

    task automatic do_reset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = idle(3'd0);
            c.rst = 1'b1;
            run_cycle(c);
        end
    endtask

    // Build the expected trace of one instruction from its class and the
    // chosen stall counts, then play it (optionally cut short by a reset).
    task automatic run_inst(input logic [31:0] inst, input int f_stall, input int m_stall,
                            input logic taken, input int abort_after);
        cyc_t q[$];
        cyc_t c;
        int   k;
        k = kind_of(inst);
        for (int i = 0; i < f_stall; i++) begin
            c = idle(3'd0); c.fv = 1'b0; c.freq = 1'b1; q.push_back(c);
        end
        c = idle(3'd0); c.fv = 1'b1; c.fd = inst; c.freq = 1'b1; q.push_back(c);
        c = idle(3'd1); q.push_back(c);
        if (k == K_ILL) begin
            for (int i = 0; i < 12; i++) begin
                c = idle(3'd5); q.push_back(c);
            end
        end else begin
            c = idle(3'd2);
            if (k == K_BRANCH) begin
                c.bt = taken; c.pw = 1'b1; c.ps = taken ? 2'b01 : 2'b00;
            end
            q.push_back(c);
            if (k == K_LOAD || k == K_STORE) begin
                for (int i = 0; i < m_stall; i++) begin
                    c = idle(3'd3); c.mr = 1'b0; c.mreq = 1'b1; c.mwe = (k == K_STORE);
                    q.push_back(c);
                end
                c = idle(3'd3); c.mr = 1'b1; c.mreq = 1'b1; c.mwe = (k == K_STORE);
                if (k == K_STORE) c.pw = 1'b1;
                q.push_back(c);
            end
            if (k != K_BRANCH && k != K_STORE) begin
                c = idle(3'd4); c.rw = 1'b1; c.pw = 1'b1;
                c.ps = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
                q.push_back(c);
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            if (abort_after >= 0 && i == abort_after) break;
            run_cycle(q[i]);
        end
        if (abort_after >= 0) do_reset(1);
    endtask

    logic [6:0] legal_ops [9] = '{7'h03, 7'h13, 7'h23, 7'h37, 7'h17,
                                  7'h63, 7'h67, 7'h6F, 7'h33};

    initial begin
        logic [31:0] w;
        i_rst = 1'b1; i_fetchValid = 1'b0; i_fetchData = '0;
        i_memReady = 1'b0; i_branchTaken = 1'b0;
        m_ir = '0; m_imm = '0; m_ill = 1'b0; m_cnt = 0;

        do_reset(2);

        // Directed program
        run_inst(32'h00500093, 0, 0, 1'b0, -1);  // addi
        run_inst(32'h0000A103, 0, 3, 1'b0, -1);  // lw, 3 wait cycles
        run_inst(32'h00208463, 0, 0, 1'b1, -1);  // beq taken
        run_inst(32'h00208463, 0, 0, 1'b0, -1);  // beq not taken
        run_inst(32'h0020A023, 0, 0, 1'b0, -1);  // sw
        run_inst(32'h00209093, 0, 0, 1'b0, -1);  // slli
        run_inst(32'h008000EF, 0, 0, 1'b0, -1);  // jal
        run_inst(32'h000080E7, 0, 0, 1'b0, -1);  // jalr
        run_inst(32'h123450B7, 1, 0, 1'b0, -1);  // lui, fetch stall
        run_inst(32'h00001097, 0, 0, 1'b0, -1);  // auipc
        run_inst(32'h002081B3, 2, 0, 1'b0, -1);  // add
        run_inst(32'h0020A023, 3, 2, 1'b0, -1);  // sw with stalls

        // Random legal instructions (pushes the 4-bit counter through wraps)
        for (int i = 0; i < 50; i++) begin
            w = $urandom;
            w[6:0] = legal_ops[$urandom_range(0, 8)];
            run_inst(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
        end

        // Illegal all-zero word: trap, immSrc held, then reset recovers
        run_inst(32'h00209093, 0, 0, 1'b0, -1);  // slli sets immSrc=010
        run_inst(32'h00000000, 0, 0, 1'b0, -1);
        do_reset(1);
        run_inst(32'h00500093, 0, 0, 1'b0, -1);

        // Another unsupported opcode (SYSTEM)
        run_inst(32'h00000073, 1, 0, 1'b0, -1);
        do_reset(1);

        // Reset while a load waits in MEM with memReady low
        run_inst(32'h00500093, 0, 0, 1'b0, -1);
        run_inst(32'h0000A103, 0, 5, 1'b0, 5);
        run_inst(32'h00500093, 0, 0, 1'b0, -1);
        run_inst(32'h0000A103, 1, 1, 1'b0, -1);

        @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
